// File: rtl/right_shift_denorm.sv
// right_shift_denorm: pipelined right-shift denormalizer with round-half-up
// rounding and an exactness flag. One shift stage per count bit, then a
// rounding stage. The whole pipe stalls together when the output is blocked.

module right_shift_denorm_stage #(
    parameter int IN_W = 22,
    parameter int SH   = 1
) (
    input  logic [IN_W-1:0] d,
    input  logic            guard,
    input  logic            sticky,
    input  logic            en,
    output logic [IN_W-1:0] shifted,
    output logic            guard_next,
    output logic            sticky_next
);
    // Bit that becomes the new guard, and the bits below it that fold into sticky.
    localparam logic [IN_W-1:0] GMASK = IN_W'(64'd1 << (SH - 1));
    localparam logic [IN_W-1:0] LMASK = IN_W'((64'd1 << (SH - 1)) - 64'd1);

    // Conditional shift by SH; the old guard is now discarded and joins sticky.
    always_comb begin
        shifted     = d;
        guard_next  = guard;
        sticky_next = sticky;
        if (en) begin
            shifted     = d >> SH;
            guard_next  = |(d & GMASK);
            sticky_next = sticky | guard | (|(d & LMASK));
        end
    end
endmodule

module right_shift_denorm #(
    parameter int IN_W  = 22,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IN_W-1:0]  in,
    input  logic [CNT_W-1:0] cnt,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IN_W-1:0]  out,
    output logic             exact,
    output logic             out_valid,
    input  logic             out_ready
);
    logic                         stall;
    logic [CNT_W:0]               vld_pipe;
    logic [CNT_W-1:0][IN_W-1:0]   d_q, d_n;
    logic [CNT_W-1:0]             g_q, s_q, g_n, s_n;

    assign out_valid = vld_pipe[CNT_W];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;

    genvar k;
    for (k = 0; k < CNT_W; k++) begin : stg
        // Count bits still needed from this stage on; c[0] enables this stage.
        logic [CNT_W-1-k:0] c;
        logic [IN_W-1:0]    pd;
        logic               pg, ps;

        if (k == 0) begin : src
            assign c  = cnt;
            assign pd = in;
            assign pg = 1'b0;
            assign ps = 1'b0;
        end else begin : src
            assign pd = d_q[k-1];
            assign pg = g_q[k-1];
            assign ps = s_q[k-1];
            // Remaining count bits travel alongside the data of this stage.
            always_ff @(posedge clk) begin
                if (rst)
                    c <= '0;
                else if (!stall)
                    c <= stg[k-1].c[CNT_W-k:1];
            end
        end

        right_shift_denorm_stage #(.IN_W(IN_W), .SH(1 << k)) u_stage (
            .d           (pd),
            .guard       (pg),
            .sticky      (ps),
            .en          (c[0]),
            .shifted     (d_n[k]),
            .guard_next  (g_n[k]),
            .sticky_next (s_n[k])
        );
    end

    // Pipeline registers: valid shift register, stage data and the rounded result.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            d_q      <= '0;
            g_q      <= '0;
            s_q      <= '0;
            out      <= '0;
            exact    <= 1'b0;
        end else if (!stall) begin
            vld_pipe <= {vld_pipe[CNT_W-1:0], in_valid && in_ready};
            d_q      <= d_n;
            g_q      <= g_n;
            s_q      <= s_n;
            // Adding the guard bit rounds half up; it cannot overflow IN_W.
            out      <= d_q[CNT_W-1] + IN_W'(g_q[CNT_W-1]);
            exact    <= ~(g_q[CNT_W-1] | s_q[CNT_W-1]);
        end
    end
endmodule

// File: tb/tb_right_shift_denorm.sv
// Testbench for right_shift_denorm: scoreboard of model results, per-scenario tasks.

module tb_right_shift_denorm;
    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [21:0] in = '0;
    logic [4:0]  cnt = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [21:0] out;
    logic        exact;
    logic        out_valid;
    logic        out_ready = 1'b0;

    right_shift_denorm dut (
        .clk(clk), .rst(rst), .in(in), .cnt(cnt), .in_valid(in_valid),
        .in_ready(in_ready), .out(out), .exact(exact), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [21:0] d; logic e; } res_t;

    res_t        sb[$];
    res_t        exp_r;
    int          checks = 0;
    int          passed = 0;
    int          cyc_n  = 0;
    logic        acc, got, was_stall, st_q = 1'b0;
    logic [21:0] pv_out, c_out = '0;
    logic        pv_exact, c_exact = 1'b0;

    // Directed vectors with hand-derived results.
    logic [21:0] dv_in  [10] = '{22'h3FFFFF, 22'h200000, 22'h000005, 22'h000006, 22'h000004,
                                 22'h000003, 22'h3FFFFF, 22'h1FFFFF, 22'h3FFFFF, 22'h000000};
    logic [4:0]  dv_cnt [10] = '{5'd0, 5'd3, 5'd1, 5'd2, 5'd3, 5'd2, 5'd22, 5'd22, 5'd31, 5'd31};
    logic [21:0] dv_out [10] = '{22'h3FFFFF, 22'h040000, 22'h000003, 22'h000002, 22'h000001,
                                 22'h000001, 22'h000001, 22'h000000, 22'h000000, 22'h000000};
    logic        dv_ex  [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reference: full-precision arithmetic on 64-bit values.
    function automatic res_t model(input logic [21:0] a, input logic [4:0] c);
        res_t            r;
        longint unsigned x = 64'(a);
        if (c == 5'd0) begin
            r.d = a;
            r.e = 1'b1;
        end else begin
            r.d = 22'((x + (64'd1 << (c - 5'd1))) >> c);
            r.e = ((x & ((64'd1 << c) - 64'd1)) == 64'd0);
        end
        return r;
    endfunction

    // One clock: drive at negedge, then sample what the next posedge will transfer.
    task automatic cyc(input logic v, input logic [21:0] d, input logic [4:0] c,
                       input logic r, input logic rs);
        @(negedge clk);
        rst = rs; in_valid = v; in = d; cnt = c; out_ready = r;
        #1;
        cyc_n++;
        was_stall = st_q; pv_out = c_out; pv_exact = c_exact;
        st_q = out_valid && !r && !rs; c_out = out; c_exact = exact;
        acc = v && in_ready && !rs;
        got = out_valid && r && !rs;
        if (rs) sb.delete();
        if (got) exp_r = (sb.size() > 0) ? sb.pop_front() : 'x;
        if (acc) sb.push_back(model(d, c));
    endtask

    task automatic test_reset;
        cyc(0, '0, '0, 1, 1);
        cyc(0, '0, '0, 1, 1);
        cyc(0, '0, '0, 1, 0);
        checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        checks++; if ({out, exact} !== 23'd0) $display("FAIL reset_data: got out=%h exact=%b want 0/0", out, exact); else passed++;
    endtask

    task automatic test_directed;
        int k = 0, t0 = 0;
        for (int i = 0; i < 40 && k < 10; i++) begin
            if (i < 10) begin
                cyc(1, dv_in[i], dv_cnt[i], 1, 0);
                if (i == 0) t0 = cyc_n;
                checks++; if (!acc) $display("FAIL directed_accept: beat %0d in_ready=%b want 1", i, in_ready); else passed++;
            end else begin
                cyc(0, '0, '0, 1, 0);
            end
            if (got) begin
                if (k == 0) begin
                    checks++;
                    if (cyc_n - t0 !== LAT) $display("FAIL directed_latency: got %0d want %0d", cyc_n - t0, LAT);
                    else passed++;
                end
                checks++;
                if ({out, exact} !== {dv_out[k], dv_ex[k]})
                    $display("FAIL directed_%0d: got out=%h exact=%b want out=%h exact=%b", k, out, exact, dv_out[k], dv_ex[k]);
                else passed++;
                k++;
            end
        end
        checks++; if (k !== 10) $display("FAIL directed_count: got %0d outputs want 10", k); else passed++;
    endtask

    task automatic test_backpressure;
        logic [21:0] bd [10];
        logic [4:0]  bc [10];
        int j = 0, n_out = 0;
        bit rose = 0;
        for (int i = 0; i < 10; i++) begin
            bd[i] = 22'($urandom);
            bc[i] = 5'($urandom);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1, bd[j], bc[j], 0, 0);
            if (acc) j++;
            if (out_valid && !rose) begin
                rose = 1;
                checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b want 0", in_ready); else passed++;
            end
            if (was_stall) begin
                checks++;
                if (out !== pv_out || exact !== pv_exact || out_valid !== 1'b1)
                    $display("FAIL bp_hold: got out=%h exact=%b want out=%h exact=%b", out, exact, pv_out, pv_exact);
                else passed++;
            end
        end
        checks++; if (j !== 6) $display("FAIL bp_captured: got %0d beats want 6", j); else passed++;
        for (int i = 0; i < 60 && (j < 10 || sb.size() > 0); i++) begin
            cyc(j < 10, bd[(j < 10) ? j : 0], bc[(j < 10) ? j : 0], 1, 0);
            if (acc) j++;
            if (got) begin
                n_out++;
                checks++;
                if ({out, exact} !== exp_r)
                    $display("FAIL bp_data_%0d: got out=%h exact=%b want out=%h exact=%b", n_out, out, exact, exp_r.d, exp_r.e);
                else passed++;
            end
        end
        checks++; if (n_out !== 10) $display("FAIL bp_drain: got %0d outputs want 10", n_out); else passed++;
    endtask

    task automatic test_random;
        int sent = 0, rcv = 0;
        logic [21:0] d = '0, m;
        logic [4:0]  c = '0;
        logic        v = 1'b0, hold = 1'b0;
        for (int i = 0; i < 60000 && rcv < 10000; i++) begin
            if (!hold) begin
                v = (sent < 10000) && ($urandom_range(1) == 1);
                d = 22'($urandom);
                c = 5'($urandom);
                m = 22'h3FFFFF;
                m = m << c;
                if ($urandom_range(3) == 0) d = d & m;
            end
            cyc(v, d, c, 1'($urandom_range(1)), 0);
            hold = v && !acc;
            if (acc) sent++;
            if (got) begin
                rcv++;
                checks++;
                if ({out, exact} !== exp_r)
                    $display("FAIL rand_data_%0d: got out=%h exact=%b want out=%h exact=%b", rcv, out, exact, exp_r.d, exp_r.e);
                else passed++;
            end
            if (was_stall) begin
                checks++;
                if (out !== pv_out || exact !== pv_exact || out_valid !== 1'b1)
                    $display("FAIL rand_hold: got out=%h exact=%b want out=%h exact=%b", out, exact, pv_out, pv_exact);
                else passed++;
            end
        end
        checks++; if (rcv !== 10000) $display("FAIL rand_count: got %0d outputs want 10000", rcv); else passed++;
    endtask

    task automatic test_reset_mid;
        int t0 = 0, n_out = 0;
        for (int i = 0; i < 4; i++) cyc(1, 22'($urandom), 5'($urandom), 0, 0);
        for (int i = 0; i < 20 && !out_valid; i++) cyc(0, '0, '0, 0, 0);
        checks++; if (out_valid !== 1'b1) $display("FAIL rmid_stalled: out_valid=%b want 1", out_valid); else passed++;
        cyc(0, '0, '0, 0, 1);
        cyc(0, '0, '0, 1, 0);
        checks++; if (out_valid !== 1'b0) $display("FAIL rmid_out_valid: got %b want 0", out_valid); else passed++;
        checks++; if (in_ready !== 1'b1) $display("FAIL rmid_in_ready: got %b want 1", in_ready); else passed++;
        checks++; if ({out, exact} !== 23'd0) $display("FAIL rmid_data: got out=%h exact=%b want 0/0", out, exact); else passed++;
        cyc(1, 22'h0ABCDE, 5'd4, 1, 0);
        t0 = cyc_n;
        for (int i = 0; i < 15; i++) begin
            cyc(0, '0, '0, 1, 0);
            if (got) begin
                n_out++;
                checks++;
                if (cyc_n - t0 !== LAT) $display("FAIL rmid_latency: got %0d want %0d", cyc_n - t0, LAT); else passed++;
                checks++;
                if ({out, exact} !== {22'h00ABCE, 1'b0})
                    $display("FAIL rmid_result: got out=%h exact=%b want out=00abce exact=0", out, exact);
                else passed++;
            end
        end
        checks++; if (n_out !== 1) $display("FAIL rmid_count: got %0d outputs want 1", n_out); else passed++;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/right_shift_denorm.md
Name: right_shift_denorm

Overview:
- Pipelined denormalizer. It takes a left-justified magnitude and the shift count produced by the normalization stage, and restores the original scale by shifting right.
- Rounding is round-half-up. An exactness flag reports whether any nonzero bits were discarded.
- It sits after the fixed-point arithmetic on normalized operands in the HOG block-normalization datapath and feeds the SVM accumulator.
- It uses a valid/ready stream on both sides.

Parameters:
- IN_W, 22, data width of the input magnitude and the output result.
- CNT_W, 5, width of the shift count. Legal counts are 0 to 2^CNT_W-1. Pipeline latency is LAT = CNT_W+1 cycles.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in  input  IN_W  normalized magnitude
- cnt  input  CNT_W  right-shift amount
- in_valid  input  1  in and cnt are valid
- in_ready  output  1  block accepts the input this cycle
- out  output  IN_W  denormalized, rounded result
- exact  output  1  1 when no nonzero bits were shifted out
- out_valid  output  1  out and exact are valid
- out_ready  input  1  downstream accepts the output this cycle

Behaviour:
- Arithmetic:
  - cnt=0: out=in, exact=1.
  - cnt>0: out = floor((in + 2^(cnt-1)) / 2^cnt), evaluated at full precision.
  - exact=1 iff (in mod 2^cnt)==0.
  - The result always fits in IN_W bits; there is no saturation path.
  - cnt=IN_W: out = in[IN_W-1].
  - cnt>IN_W: out=0, exact=(in==0).
- Pipeline structure:
  - Stages 0..CNT_W-1 each conditionally shift right by 2^k when cnt bit k is set.
  - Each stage carries a guard bit (last bit shifted out) and a sticky bit (OR of all earlier discarded bits).
  - The final stage adds the guard bit to the shifted value and computes exact = ~(guard|sticky).
  - Each stage holds a valid bit plus its data registers.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Global stall: stall = out_valid && !out_ready. When stall=1, every pipeline register, including the valid bits, holds its value.
  - in_ready = !stall. This is combinational from out_valid and out_ready; there is no combinational path from in_valid.
  - When stall=0, every stage advances one position. Stage 0 valid loads in_valid && in_ready.
  - Bubbles are not compressed. Throughput is 1 per cycle while out_ready=1.
- Latency: a beat accepted in cycle t appears with out_valid=1 in cycle t+LAT when there is no stall. Stall cycles add one cycle each.
- Ordering: strict FIFO. No beat is dropped or duplicated.
- Reset:
  - Synchronous; takes priority over stall.
  - Clears all valid bits, so out_valid=0 and in_ready=1 on the cycle after rst is sampled.
  - out=0 and exact=0 after reset; data registers are cleared.
  - Reset mid-stream discards all in-flight beats.
- out and exact remain stable while out_valid=1 and out_ready=0.
- Simultaneous input and output transfer in the same cycle is legal and is the normal streaming case.

Test Plan:
- Reset, then stream with out_ready=1. Expected outputs, each after LAT=6 cycles:
  - in=0x3FFFFF, cnt=0 -> out=0x3FFFFF, exact=1.
  - in=0x200000, cnt=3 -> out=0x040000, exact=1.
  - in=0x000005, cnt=1 -> out=0x000003, exact=0.
- Rounding at ties and near-ties:
  - in=0x000006, cnt=2 -> out=0x000002, exact=0.
  - in=0x000004, cnt=3 -> out=0x000001, exact=0.
  - in=0x000003, cnt=2 -> out=0x000001, exact=0.
- Large counts:
  - in=0x3FFFFF, cnt=22 -> out=1, exact=0.
  - in=0x1FFFFF, cnt=22 -> out=0, exact=0.
  - in=0x3FFFFF, cnt=31 -> out=0, exact=0.
  - in=0, cnt=31 -> out=0, exact=1.
- Back-pressure:
  - Drive 10 consecutive random beats with in_valid=1 and hold out_ready=0.
  - Expected: in_ready falls in the cycle out_valid first rises, and exactly 6 beats are captured.
  - Release out_ready: the captured beats drain in order, then the remaining 4 are accepted; all 10 match the reference model.
- Random out_ready (50%) with random in_valid over 10k beats -> the output sequence matches a scoreboard model exactly; out and exact never change while out_valid && !out_ready.
- Reset mid-operation:
  - Load 4 beats, then assert rst for 1 cycle while the pipeline is stalled.
  - Expected next cycle: out_valid=0 and in_ready=1. No stale beat ever emerges, and a new beat emerges after exactly LAT cycles.
